// File: rtl/general_defs.sv
// Shared widths, loader length width and the loader state encoding.
package general_defs;

   localparam int HALF_WORD        = 16;
   localparam int WORD             = 32;
   localparam int LOADER_LEN_WIDTH = 16;

   typedef enum logic [2:0] {
      LEN_LO,
      LEN_HI,
      DATA_LO,
      DATA_HI,
      CSUM,
      DONE,
      ERROR
   } loader_state_t;

endpackage

// File: rtl/halfword_assembler.sv
// Pairs a low and a high stream byte into a halfword and flags it with a one-cycle valid pulse.
module halfword_assembler
   import general_defs::*;
(
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 lo_load_i,
   input  logic                 hi_load_i,
   input  logic [7:0]           byte_i,
   output logic [HALF_WORD-1:0] halfword_o,
   output logic                 valid_o
);

   logic [7:0]           lo_q;
   logic [HALF_WORD-1:0] halfword_q;
   logic                 valid_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         lo_q       <= '0;
         halfword_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         valid_q <= hi_load_i;
         if (lo_load_i) begin
            lo_q <= byte_i;
         end
         // The halfword holds its value between pulses so memory sees stable data.
         if (hi_load_i) begin
            halfword_q <= {byte_i, lo_q};
         end
      end
   end

   assign halfword_o = halfword_q;
   assign valid_o    = valid_q;

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed little-endian image into instruction memory, holding the CPU in reset.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module program_loader
   import general_defs::*;
#(
   parameter int              MAX_HALFWORDS = 512,
   parameter logic [WORD-1:0] BASE_ADDR     = 32'h0000_0000
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 byte_valid_i,
   input  logic [7:0]           byte_i,
   input  logic                 reload_i,
   output logic                 byte_ready_o,
   output logic                 program_mem_write_en_o,
   output logic [HALF_WORD-1:0] instruction_o,
   output logic [WORD-1:0]      instruction_addr_o,
   output logic                 cpu_reset_o,
   output logic                 load_done_o,
   output logic                 load_error_o
);

   localparam logic [LOADER_LEN_WIDTH-1:0] MAX_LEN = LOADER_LEN_WIDTH'(MAX_HALFWORDS);
   localparam logic [LOADER_LEN_WIDTH-1:0] ONE     = LOADER_LEN_WIDTH'(1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   localparam loader_state_t END_STATE = CSUM;
   logic [7:0] csum_q;
`else
   localparam loader_state_t END_STATE = DONE;
`endif

   loader_state_t               state_q, state_d;
   logic [LOADER_LEN_WIDTH-1:0] len_q, count_q, len_full;
   logic [WORD-1:0]             addr_q;
   logic                        done_q, error_q, cpu_reset_q;
   logic                        accept, reload_ok;

   assign byte_ready_o = (state_q != DONE) && (state_q != ERROR);
   assign accept       = byte_valid_i && byte_ready_o;
   assign reload_ok    = reload_i && !byte_ready_o;
   assign len_full     = {byte_i, len_q[7:0]};

   always_comb begin
      state_d = state_q;
      case (state_q)
         LEN_LO:  if (accept) state_d = LEN_HI;
         LEN_HI: begin
            if (accept) begin
               if (len_full == '0)          state_d = END_STATE;
               else if (len_full > MAX_LEN) state_d = ERROR;
               else                         state_d = DATA_LO;
            end
         end
         DATA_LO: if (accept) state_d = DATA_HI;
         DATA_HI: begin
            if (accept) begin
               state_d = (count_q + ONE == len_q) ? END_STATE : DATA_LO;
            end
         end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         CSUM:    if (accept) state_d = (byte_i == csum_q) ? DONE : ERROR;
`endif
         DONE:    if (reload_ok) state_d = LEN_LO;
         ERROR:   if (reload_ok) state_d = LEN_LO;
         default: state_d = LEN_LO;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= LEN_LO;
         len_q       <= '0;
         count_q     <= '0;
         addr_q      <= BASE_ADDR;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         cpu_reset_q <= 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         state_q <= state_d;
         if (accept && state_q == LEN_LO) len_q[7:0]  <= byte_i;
         if (accept && state_q == LEN_HI) len_q[15:8] <= byte_i;
         if (accept && state_q == DATA_HI) begin
            addr_q  <= BASE_ADDR + WORD'({count_q, 1'b0});
            count_q <= count_q + ONE;
         end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         if (accept) csum_q <= csum_q ^ byte_i;
`endif
         // After a final write, DONE flags wait one cycle so they trail the last strobe.
         if (state_d == DONE && state_q != DATA_HI) begin
            done_q      <= 1'b1;
            cpu_reset_q <= 1'b0;
         end
         if (state_d == ERROR) error_q <= 1'b1;
         if (reload_ok) begin
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
            count_q     <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
         end
      end
   end

   halfword_assembler u_assembler (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .lo_load_i  (accept && state_q == DATA_LO),
      .hi_load_i  (accept && state_q == DATA_HI),
      .byte_i     (byte_i),
      .halfword_o (instruction_o),
      .valid_o    (program_mem_write_en_o)
   );

   assign instruction_addr_o = addr_q;
   assign cpu_reset_o        = cpu_reset_q;
   assign load_done_o        = done_q;
   assign load_error_o       = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed and randomized image loads checked against a halfword-list model of the loader.
module tb_program_loader;
   import general_defs::*;

   localparam logic [31:0] BASE = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset_i, byte_valid_i, reload_i;
   logic [7:0]  byte_i;
   logic        byte_ready_o, program_mem_write_en_o, cpu_reset_o, load_done_o, load_error_o;
   logic [15:0] instruction_o;
   logic [31:0] instruction_addr_o;

   program_loader dut (
      .clk_i                  (clk),
      .reset_i                (reset_i),
      .byte_valid_i           (byte_valid_i),
      .byte_i                 (byte_i),
      .reload_i               (reload_i),
      .byte_ready_o           (byte_ready_o),
      .program_mem_write_en_o (program_mem_write_en_o),
      .instruction_o          (instruction_o),
      .instruction_addr_o     (instruction_addr_o),
      .cpu_reset_o            (cpu_reset_o),
      .load_done_o            (load_done_o),
      .load_error_o           (load_error_o)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass = 0;
   int          strobe_total = 0;
   int          consec_total = 0;
   bit          prev_we = 1'b0;
   logic [15:0] img[$];
   logic [7:0]  csum;

   // Strobe counter and back-to-back strobe detector.
   always @(negedge clk) begin
      if (program_mem_write_en_o === 1'b1) begin
         strobe_total++;
         if (prev_we) consec_total++;
      end
      prev_we = (program_mem_write_en_o === 1'b1);
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic do_reset();
      reset_i = 1'b1; byte_valid_i = 1'b0; reload_i = 1'b0; byte_i = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      reset_i = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      byte_valid_i = 1'b1;
      byte_i       = b;
      csum         = csum ^ b;
      @(posedge clk);
      #1;
      byte_valid_i = 1'b0;
      byte_i       = 8'($urandom);
   endtask

   // Idle cycles with junk data; reload pulses here must be ignored mid-load.
   task automatic gap(input int lo, input int hi);
      int n;
      n = int'($urandom_range(hi, lo));
      repeat (n) begin
         byte_valid_i = 1'b0;
         byte_i       = 8'($urandom);
         reload_i     = 1'($urandom);
         @(posedge clk);
         #1;
      end
      reload_i = 1'b0;
   endtask

   task automatic do_reload(input string name);
      reload_i = 1'b1;
      @(posedge clk);
      #1;
      reload_i = 1'b0;
      check({name, "/reload_ready"}, 32'(byte_ready_o), 1);
      check({name, "/reload_done"}, 32'(load_done_o), 0);
      check({name, "/reload_error"}, 32'(load_error_o), 0);
      check({name, "/reload_cpu_reset"}, 32'(cpu_reset_o), 1);
   endtask

   task automatic load_image(input string name, input int glo, input int ghi, input bit corrupt);
      int          n;
      int          base_strobes;
      logic [15:0] nn;
      logic [15:0] h;
      logic [7:0]  cb;
      n            = img.size();
      base_strobes = strobe_total;
      nn           = 16'(n);
      csum         = 8'h00;
      gap(glo, ghi); send(nn[7:0]);
      gap(glo, ghi); send(nn[15:8]);
      for (int i = 0; i < n; i++) begin
         h = img[i];
         gap(glo, ghi); send(h[7:0]);
         gap(glo, ghi); send(h[15:8]);
         check({name, "/we"}, 32'(program_mem_write_en_o), 1);
         check({name, "/instr"}, 32'(instruction_o), 32'(h));
         check({name, "/addr"}, instruction_addr_o, BASE + 32'(2 * i));
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      cb = corrupt ? ((csum == 8'h00) ? 8'hFF : 8'h00) : csum;
      gap(glo, ghi); send(cb);
      check({name, "/done"}, 32'(load_done_o), corrupt ? 0 : 1);
      check({name, "/error"}, 32'(load_error_o), corrupt ? 1 : 0);
      check({name, "/cpu_reset"}, 32'(cpu_reset_o), corrupt ? 1 : 0);
`else
      cb = {7'd0, corrupt};
      if (n != 0) begin
         check({name, "/done_early"}, 32'(load_done_o), 0);
         @(posedge clk);
         #1;
      end
      check({name, "/we_after"}, 32'(program_mem_write_en_o), 0);
      check({name, "/done"}, 32'(load_done_o), 1);
      check({name, "/error"}, 32'(load_error_o), 0);
      check({name, "/cpu_reset"}, 32'(cpu_reset_o), 0);
`endif
      check({name, "/ready_end"}, 32'(byte_ready_o), 0);
      check({name, "/strobe_count"}, 32'(strobe_total - base_strobes), 32'(n));
      check({name, "/no_back_to_back"}, 32'(consec_total), 0);
      if (n > 0) check({name, "/instr_hold"}, 32'(instruction_o), 32'(img[n - 1]));
      $display("image %s: N=%0d strobes=%0d done=%0b error=%0b last_byte=%0h",
               name, n, strobe_total - base_strobes, load_done_o, load_error_o, cb);
   endtask

   initial begin
      int          base_strobes;
      int          n;
      do_reset();
      check("reset/ready", 32'(byte_ready_o), 1);
      check("reset/we", 32'(program_mem_write_en_o), 0);
      check("reset/instr", 32'(instruction_o), 0);
      check("reset/addr", instruction_addr_o, BASE);
      check("reset/cpu_reset", 32'(cpu_reset_o), 1);
      check("reset/done", 32'(load_done_o), 0);
      check("reset/error", 32'(load_error_o), 0);
      $display("reset applied");

      img = '{16'h1234, 16'h5678};
      load_image("n2", 0, 0, 1'b0);

      do_reload("n0");
      img.delete();
      load_image("n0", 0, 0, 1'b0);

      do_reload("n513");
      base_strobes = strobe_total;
      csum = 8'h00;
      send(8'h01); send(8'h02);
      check("n513/error", 32'(load_error_o), 1);
      check("n513/ready", 32'(byte_ready_o), 0);
      check("n513/cpu_reset", 32'(cpu_reset_o), 1);
      send(8'h55);
      check("n513/ignored_error", 32'(load_error_o), 1);
      check("n513/ignored_done", 32'(load_done_o), 0);
      check("n513/strobes", 32'(strobe_total - base_strobes), 0);
      $display("image n513: length rejected error=%0b", load_error_o);

      do_reload("toggle");
      img = '{16'hBEEF};
      load_image("toggle", 1, 1, 1'b0);

      do_reload("midreset");
      send(8'h02); send(8'h00); send(8'hAA); send(8'hBB); send(8'hCC);
      reset_i = 1'b1; byte_valid_i = 1'b1; byte_i = 8'hDD;
      @(posedge clk);
      #1;
      check("midreset/we", 32'(program_mem_write_en_o), 0);
      check("midreset/addr", instruction_addr_o, BASE);
      check("midreset/instr", 32'(instruction_o), 0);
      check("midreset/ready", 32'(byte_ready_o), 1);
      check("midreset/cpu_reset", 32'(cpu_reset_o), 1);
      reset_i = 1'b0; byte_valid_i = 1'b0;
      $display("load abandoned by reset");
      img = '{16'($urandom)};
      load_image("after_reset", 0, 0, 1'b0);

      for (int k = 0; k < 6; k++) begin
         do_reload("random");
         img.delete();
         n = int'($urandom_range(12, 1));
         for (int i = 0; i < n; i++) img.push_back(16'($urandom));
         load_image("random", 0, 2, 1'b0);
      end

      do_reload("n512");
      img.delete();
      for (int i = 0; i < 512; i++) img.push_back(16'($urandom));
      load_image("n512", 0, 0, 1'b0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      do_reload("csum_ok");
      img = '{16'h1234};
      load_image("csum_ok", 0, 0, 1'b0);
      do_reload("csum_bad");
      load_image("csum_bad", 0, 0, 1'b1);
      do_reload("csum_retry");
      load_image("csum_retry", 0, 1, 1'b0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
